// File: rtl/lcd_bus_driver.sv
// HD44780 bus driver: power-on init, enable-strobe timing and per-command execution waits.
// Latency: EN rises 3+EN_SETUP cycles after a rdy pulse; next rdy follows the exec wait.
// Backpressure: the generator is paced by rdy pulses only; cmd_data is sampled once per request.
module lcd_bus_driver #(
    parameter int EN_SETUP     = 2,
    parameter int EN_HIGH      = 12,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000,
    parameter int INIT_WAIT    = 750000,
    parameter int WAIT2_CYCLES = 100000000,
    parameter int IDLE_GAP     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] cmd_data,
    output logic        rdy,
    output logic        init_done,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_ON,
    output logic        LCD_BLON
);

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = maxi(maxi(maxi(INIT_WAIT, WAIT2_CYCLES), maxi(CLEAR_WAIT, CMD_WAIT)),
                               maxi(maxi(EN_SETUP, EN_HIGH), IDLE_GAP));
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    typedef enum logic [3:0] {
        PWR_WAIT, REQ, SETTLE, DECODE, SETUP, PULSE, HOLD, EXEC, DELAY
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_lim, cnt_val, exec_len, bus_wait;
    logic            cnt_load, cnt_done;
    logic [11:0]     cmd_q;
    logic [1:0]      init_idx, init_nxt;
    logic            bus_load, bus_rs, set_done;
    logic [7:0]      bus_byte;
    logic [3:0]      op;
    logic [7:0]      payload, col_diff;
    logic            line;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

    assign cnt_done = (cnt == cnt_lim);
    assign init_nxt = init_idx + 2'd1;
    assign op       = cmd_q[11:8];
    assign payload  = cmd_q[7:0];
    // Line 2 starts at generator address 40; columns wrap modulo 16.
    assign line     = (payload >= 8'd40);
    assign col_diff = payload - (line ? 8'd40 : 8'd0);

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        bus_load = 1'b0;
        bus_byte = 8'h00;
        bus_rs   = 1'b0;
        bus_wait = '0;
        set_done = 1'b0;
        case (state)
            PWR_WAIT: if (cnt_done) begin
                bus_load = 1'b1;
                bus_byte = init_byte(2'd0);
                bus_wait = CW'(CMD_WAIT - 1);
                state_n  = SETUP;
                cnt_load = 1'b1;
                cnt_val  = CW'(EN_SETUP - 1);
            end
            REQ: begin
                state_n  = SETTLE;
                cnt_load = 1'b1;
                cnt_val  = CW'(1);
            end
            SETTLE: if (cnt_done) state_n = DECODE;
            DECODE: begin
                cnt_load = 1'b1;
                state_n  = SETUP;
                cnt_val  = CW'(EN_SETUP - 1);
                bus_wait = CW'(CMD_WAIT - 1);
                case (op)
                    4'h0: begin
                        bus_load = 1'b1;
                        bus_byte = 8'h01;
                        bus_wait = CW'(CLEAR_WAIT - 1);
                    end
                    4'h1: begin
                        bus_load = 1'b1;
                        bus_rs   = 1'b1;
                        bus_byte = payload;
                    end
                    4'h3: begin
                        bus_load = 1'b1;
                        bus_byte = {1'b1, line, 2'b00, col_diff[3:0]};
                    end
                    4'h4: begin
                        state_n = DELAY;
                        cnt_val = CW'(WAIT2_CYCLES - 1);
                    end
                    default: begin
                        state_n = DELAY;
                        cnt_val = CW'(IDLE_GAP - 1);
                    end
                endcase
            end
            SETUP: if (cnt_done) begin
                state_n  = PULSE;
                cnt_load = 1'b1;
                cnt_val  = CW'(EN_HIGH - 1);
            end
            PULSE: if (cnt_done) state_n = HOLD;
            HOLD: begin
                state_n  = EXEC;
                cnt_load = 1'b1;
                cnt_val  = exec_len;
            end
            EXEC: if (cnt_done) begin
                if (init_done || init_idx == 2'd3) begin
                    state_n  = REQ;
                    set_done = ~init_done;
                end else begin
                    bus_load = 1'b1;
                    bus_byte = init_byte(init_nxt);
                    bus_wait = (init_nxt == 2'd3) ? CW'(CLEAR_WAIT - 1) : CW'(CMD_WAIT - 1);
                    state_n  = SETUP;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(EN_SETUP - 1);
                end
            end
            DELAY: if (cnt_done) state_n = REQ;
            default: state_n = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            cnt_lim   <= CW'(INIT_WAIT - 1);
            cmd_q     <= '0;
            init_idx  <= 2'd0;
            exec_len  <= '0;
            init_done <= 1'b0;
            rdy       <= 1'b0;
            LCD_EN    <= 1'b0;
            LCD_DATA  <= 8'h00;
            LCD_RS    <= 1'b0;
        end else begin
            state <= state_n;
            if (cnt_load) begin
                cnt     <= '0;
                cnt_lim <= cnt_val;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == SETTLE && cnt_done)
                cmd_q <= cmd_data;
            if (state == EXEC && cnt_done && !init_done)
                init_idx <= init_nxt;
            if (bus_load) begin
                LCD_DATA <= bus_byte;
                LCD_RS   <= bus_rs;
                exec_len <= bus_wait;
            end
            if (set_done)
                init_done <= 1'b1;
            rdy    <= (state == REQ);
            LCD_EN <= (state_n == PULSE);
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Randomized command stream against a cycle-timeline model of the LCD bus driver.
module tb_lcd_bus_driver;

    localparam int EN_SETUP     = 1;
    localparam int EN_HIGH      = 2;
    localparam int CMD_WAIT     = 4;
    localparam int CLEAR_WAIT   = 8;
    localparam int INIT_WAIT    = 10;
    localparam int WAIT2_CYCLES = 20;
    localparam int IDLE_GAP     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cmd_data = 12'hF00;
    logic        rdy, init_done, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;
    logic [7:0]  LCD_DATA;

    lcd_bus_driver #(
        .EN_SETUP(EN_SETUP), .EN_HIGH(EN_HIGH), .CMD_WAIT(CMD_WAIT), .CLEAR_WAIT(CLEAR_WAIT),
        .INIT_WAIT(INIT_WAIT), .WAIT2_CYCLES(WAIT2_CYCLES), .IDLE_GAP(IDLE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .rdy(rdy), .init_done(init_done),
        .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
        .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       rs;
    } pulse_t;

    pulse_t      exp_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc, exp_rdy, exp_done, n_cmds, dir_idx;
    int          en_rise;
    logic        en_prev, rdy_prev, done_prev, en_rs;
    logic [7:0]  en_data;
    logic [11:0] dir_cmds [10] = '{12'h141, 12'h304, 12'h32B, 12'h336, 12'h314,
                                   12'hF00, 12'hF00, 12'h400, 12'h400, 12'h000};
    logic [7:0]  init_bytes [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_bus(input logic [11:0] c);
        return (c[11:8] == 4'h0) || (c[11:8] == 4'h1) || (c[11:8] == 4'h3);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [11:0] c);
        int p, ln, col;
        p = int'(c[7:0]);
        if (c[11:8] == 4'h0) return 8'h01;
        if (c[11:8] == 4'h1) return c[7:0];
        ln  = (p >= 40) ? 1 : 0;
        col = (p - 40 * ln) % 16;
        return 8'(128 + 64 * ln + col);
    endfunction

    function automatic int ref_gap(input logic [11:0] c);
        if (is_bus(c))
            return 3 + EN_SETUP + EN_HIGH + 1 + ((c[11:8] == 4'h0) ? CLEAR_WAIT : CMD_WAIT) + 1;
        return 3 + ((c[11:8] == 4'h4) ? WAIT2_CYCLES : IDLE_GAP) + 1;
    endfunction

    function automatic logic [11:0] next_cmd();
        logic [3:0] ops [8] = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h4, 4'hF, 4'h0};
        logic [3:0] op;
        if (dir_idx < 10) begin
            dir_idx++;
            return dir_cmds[dir_idx - 1];
        end
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 7)];
        return {op, 8'($urandom_range(0, 255))};
    endfunction

    task automatic model_reset();
        pulse_t p;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            p.cyc  = INIT_WAIT + EN_SETUP + k * (EN_SETUP + EN_HIGH + 1 + CMD_WAIT);
            p.data = init_bytes[k];
            p.rs   = 1'b0;
            exp_q.push_back(p);
        end
        exp_done  = p.cyc + EN_HIGH + 1 + CLEAR_WAIT;
        exp_rdy   = exp_done + 1;
        en_prev   = 1'b0;
        rdy_prev  = 1'b0;
        done_prev = 1'b0;
        cyc       = 0;
    endtask

    // Called with rst already high: one sampled reset edge, then release.
    task automatic do_reset();
        @(posedge clk);
        #1;
        chk("rst_en", 32'(LCD_EN), 0);
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_data", 32'(LCD_DATA), 0);
        chk("rst_rs", 32'(LCD_RS), 0);
        chk("rst_on_blon", {30'd0, LCD_ON, LCD_BLON}, 3);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic tick();
        pulse_t      p;
        logic [11:0] c;
        @(posedge clk);
        #1;
        cyc++;
        chk("rw", 32'(LCD_RW), 0);
        if (LCD_EN && !en_prev) begin
            if (exp_q.size() == 0) begin
                chk("en_unexpected", 1, 0);
            end else begin
                p = exp_q.pop_front();
                chk("en_rise_cycle", cyc, p.cyc);
                chk("en_data", 32'(LCD_DATA), 32'(p.data));
                chk("en_rs", 32'(LCD_RS), 32'(p.rs));
            end
            en_rise = cyc;
            en_data = LCD_DATA;
            en_rs   = LCD_RS;
        end else if (LCD_EN) begin
            chk("bus_stable", {23'd0, LCD_RS, LCD_DATA}, {23'd0, en_rs, en_data});
        end else if (en_prev) begin
            chk("en_width", cyc - en_rise, EN_HIGH);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("en_missing", 0, 1);
            p = exp_q.pop_front();
        end
        if (init_done != done_prev)
            chk(init_done ? "init_done_cycle" : "init_done_sticky",
                init_done ? cyc : 0, init_done ? exp_done : 1);
        if (rdy) begin
            chk("rdy_cycle", cyc, exp_rdy);
            chk("rdy_gap", 32'(rdy_prev), 0);
            chk("rdy_after_init", 32'(init_done), 1);
            c        = next_cmd();
            cmd_data = c;
            if (is_bus(c)) begin
                p.cyc  = cyc + 3 + EN_SETUP;
                p.data = ref_byte(c);
                p.rs   = (c[11:8] == 4'h1);
                exp_q.push_back(p);
            end
            exp_rdy = cyc + ref_gap(c);
            n_cmds++;
        end else if (cyc == exp_rdy) begin
            chk("rdy_missing", 0, 1);
        end
        en_prev   = LCD_EN;
        rdy_prev  = rdy;
        done_prev = init_done;
    endtask

    initial begin
        int guard;
        dir_idx = 0;
        n_cmds  = 0;
        rst     = 1'b1;
        do_reset();
        guard = 0;
        while (n_cmds < 40 && guard < 4000) begin
            tick();
            guard++;
        end
        chk("phase1_cmds", 32'(n_cmds >= 40), 1);

        guard = 0;
        while (!LCD_EN && guard < 200) begin
            tick();
            guard++;
        end
        chk("en_wait", 32'(LCD_EN), 1);
        rst = 1'b1;
        do_reset();

        n_cmds = 0;
        guard  = 0;
        while (n_cmds < 12 && guard < 3000) begin
            tick();
            guard++;
        end
        chk("phase2_cmds", 32'(n_cmds >= 12), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
